// File: rtl/tftlcd_pixfifo.sv
// Frame-aligned pixel FIFO feeding the tftlcd timing generator.
// Pops one pixel per DE cycle and keeps producer frames locked to display VSYNC via a sof marker.
module tftlcd_pixfifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 24
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_valid,
    input  logic [WIDTH-1:0]           i_wr_pixel,
    input  logic                       i_wr_sof,
    output logic                       o_wr_ready,
    input  logic                       i_de,
    input  logic                       i_vsync,
    input  logic                       i_clr_err,
    output logic [WIDTH-1:0]           o_pixel,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_underflow,
    output logic                       o_sof_err,
    output logic                       o_running
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] pixel_q, pixel_d;
    logic             uf_q, uf_d, se_q, se_d;
    logic             vs_q, first_q, first_d;

    logic [WIDTH:0]   mem [DEPTH];
    logic [WIDTH:0]   head;
    logic             vs_rise, push, wr_en, pop, flush, uf_set, se_set;

    assign head       = mem[rptr_q];
    assign vs_rise    = i_vsync & ~vs_q;
    assign o_wr_ready = ~i_rst & ((state_q == S_IDLE) | (level_q != FULL_LVL));
    assign push       = i_wr_valid & o_wr_ready;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        pixel_d = pixel_q;
        first_d = first_q;
        wr_en   = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        uf_set  = 1'b0;
        se_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                wptr_d  = '0;
                rptr_d  = '0;
                level_d = '0;
                pixel_d = '0;
                // Only a sof pixel can restart the pipe; everything else is dropped.
                if (push && i_wr_sof) begin
                    wr_en   = 1'b1;
                    wptr_d  = AW'(1);
                    level_d = LW'(1);
                    state_d = S_WAIT_VS;
                end
            end
            S_WAIT_VS: begin
                pixel_d = '0;
                wr_en   = push;
                if (vs_rise) begin
                    state_d = S_RUN;
                    first_d = 1'b1;
                end
            end
            S_RUN: begin
                if (i_de) begin
                    if (level_q == '0) begin
                        uf_set = 1'b1;
                        flush  = 1'b1;
                    end else if (head[WIDTH] != first_q) begin
                        se_set = 1'b1;
                        flush  = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pixel_d = head[WIDTH-1:0];
                        first_d = 1'b0;
                    end
                end
                if (vs_rise) first_d = 1'b1;
                wr_en = push & ~flush;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            if (flush) begin
                state_d = S_IDLE;
                pixel_d = '0;
                wptr_d  = '0;
                rptr_d  = '0;
                level_d = '0;
            end else begin
                if (wr_en) wptr_d = wptr_q + AW'(1);
                if (pop)   rptr_d = rptr_q + AW'(1);
                level_d = level_q + LW'(wr_en) - LW'(pop);
            end
        end

        uf_d = uf_set | (uf_q & ~i_clr_err);
        se_d = se_set | (se_q & ~i_clr_err);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            pixel_q <= '0;
            uf_q    <= 1'b0;
            se_q    <= 1'b0;
            vs_q    <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            pixel_q <= pixel_d;
            uf_q    <= uf_d;
            se_q    <= se_d;
            vs_q    <= i_vsync;
            first_q <= first_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wptr_q] <= {i_wr_sof, i_wr_pixel};
    end

    assign o_pixel     = pixel_q;
    assign o_level     = level_q;
    assign o_underflow = uf_q;
    assign o_sof_err   = se_q;
    assign o_running   = (state_q == S_RUN);
endmodule

// File: tb/tb_tftlcd_pixfifo.sv
// Bench for tftlcd_pixfifo: directed scenarios plus random traffic against a queue-based frame model.
module tb_tftlcd_pixfifo;
    localparam int DEPTH = 1024;
    localparam int WIDTH = 24;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_pixel = '0;
    logic             wr_sof = 1'b0;
    logic             wr_ready;
    logic             de = 1'b0;
    logic             vsync = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] pixel;
    logic [LW-1:0]    level;
    logic             underflow, sof_err, running;

    tftlcd_pixfifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_valid(wr_valid), .i_wr_pixel(wr_pixel), .i_wr_sof(wr_sof), .o_wr_ready(wr_ready),
        .i_de(de), .i_vsync(vsync), .i_clr_err(clr_err),
        .o_pixel(pixel), .o_level(level), .o_underflow(underflow), .o_sof_err(sof_err),
        .o_running(running)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: locked = a sof pixel has been captured; displaying = frames are being popped.
    bit               m_locked, m_displaying, m_first, m_vsprev, m_uf, m_se;
    logic [WIDTH-1:0] m_pix;
    logic [WIDTH:0]   m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_displaying = 0; m_first = 0; m_vsprev = 0;
        m_uf = 0; m_se = 0; m_pix = '0;
        m_q.delete();
    endtask

    task automatic tick();
        bit rdy, push, vsr, flush, uf_set, se_set;
        logic [WIDTH:0] h;
        rdy    = !m_locked || (m_q.size() < DEPTH);
        chk("ready", 32'(wr_ready), 32'(rdy));
        push   = wr_valid && rdy;
        vsr    = vsync && !m_vsprev;
        flush  = 0; uf_set = 0; se_set = 0;
        if (!m_locked) begin
            m_pix = '0;
            if (push && wr_sof) begin
                m_q.push_back({1'b1, wr_pixel});
                m_locked = 1;
            end
        end else if (!m_displaying) begin
            m_pix = '0;
            if (push) m_q.push_back({wr_sof, wr_pixel});
            if (vsr) begin
                m_displaying = 1;
                m_first = 1;
            end
        end else begin
            if (de) begin
                if (m_q.size() == 0) begin
                    uf_set = 1; flush = 1;
                end else begin
                    h = m_q.pop_front();
                    if (h[WIDTH] != m_first) begin
                        se_set = 1; flush = 1;
                    end else begin
                        m_pix = h[WIDTH-1:0];
                        m_first = 0;
                    end
                end
            end
            if (vsr) m_first = 1;
            if (flush) begin
                m_q.delete();
                m_locked = 0; m_displaying = 0; m_pix = '0;
            end else if (push) begin
                m_q.push_back({wr_sof, wr_pixel});
            end
        end
        if (clr_err) begin m_uf = 0; m_se = 0; end
        if (uf_set) m_uf = 1;
        if (se_set) m_se = 1;
        m_vsprev = vsync;
        @(posedge clk);
        #1;
        chk("pixel", 32'(pixel), 32'(m_pix));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("sof_err", 32'(sof_err), 32'(m_se));
        chk("running", 32'(running), 32'(m_displaying));
    endtask

    task automatic cyc(input bit v, input logic [WIDTH-1:0] px, input bit sof,
                       input bit d, input bit vs, input bit clr);
        wr_valid = v; wr_pixel = px; wr_sof = sof; de = d; vsync = vs; clr_err = clr;
        tick();
    endtask

    task automatic do_reset();
        wr_valid = 0; de = 0; vsync = 0; clr_err = 0;
        rst = 1;
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_flags", 32'({underflow, sof_err}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("rst_rel_ready", 32'(wr_ready), 32'd1);
    endtask

    task automatic vs_pulse();
        cyc(0, '0, 0, 0, 1, 0);
        cyc(0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Basic stream
        cyc(1, 24'h000001, 1, 0, 0, 0);
        for (int i = 2; i <= 6; i++) cyc(1, 24'(i), 0, 0, 0, 0);
        vs_pulse();
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1, 0, 0);
        chk("basic_px4", 32'(pixel), 32'h4);
        chk("basic_lvl", 32'(level), 32'd2);
        chk("basic_run", 32'(running), 32'd1);

        // Full
        do_reset();
        cyc(1, 24'h100000, 1, 0, 0, 0);
        for (int i = 1; i < DEPTH; i++) cyc(1, 24'($urandom), 0, 0, 0, 0);
        chk("full_lvl", 32'(level), 32'(DEPTH));
        chk("full_ready", 32'(wr_ready), 32'd0);
        cyc(1, 24'hABCDEF, 0, 0, 0, 0);
        vs_pulse();
        cyc(1, 24'h123456, 0, 1, 0, 0);
        chk("full_pop_px", 32'(pixel), 32'h100000);
        chk("full_pop_lvl", 32'(level), 32'(DEPTH - 1));
        chk("full_ready_back", 32'(wr_ready), 32'd1);

        // Underflow, then clear
        do_reset();
        cyc(1, 24'h0000AA, 1, 0, 0, 0);
        cyc(1, 24'h0000BB, 0, 0, 0, 0);
        vs_pulse();
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0, 0);
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_run", 32'(running), 32'd0);
        cyc(0, '0, 0, 0, 0, 1);
        chk("uf_clr", 32'(underflow), 32'd0);

        // Misalignment: non-sof head at frame start
        cyc(1, 24'h000011, 1, 0, 0, 0);
        cyc(1, 24'h000012, 0, 0, 0, 0);
        vs_pulse();
        for (int i = 0; i < 2; i++) cyc(0, '0, 0, 1, 0, 0);
        cyc(1, 24'h000013, 0, 0, 0, 0);
        vs_pulse();
        cyc(0, '0, 0, 1, 0, 0);
        chk("sof_err_a", 32'(sof_err), 32'd1);
        chk("sof_err_a_lvl", 32'(level), 32'd0);
        cyc(0, '0, 0, 0, 0, 1);

        // Misalignment: sof head mid-frame
        cyc(1, 24'h000021, 1, 0, 0, 0);
        cyc(1, 24'h000022, 0, 0, 0, 0);
        cyc(1, 24'h000023, 1, 0, 0, 0);
        vs_pulse();
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0, 0);
        chk("sof_err_b", 32'(sof_err), 32'd1);

        // Resync from IDLE
        for (int i = 0; i < 5; i++) cyc(1, 24'($urandom), 0, 0, 0, 0);
        chk("resync_drop", 32'(level), 32'd0);
        cyc(1, 24'h000031, 1, 0, 0, 0);
        chk("resync_lvl", 32'(level), 32'd1);

        // Mid-frame reset
        do_reset();
        cyc(1, 24'h000001, 1, 0, 0, 0);
        for (int i = 1; i < 350; i++) cyc(1, 24'(i + 1), 0, 0, 0, 0);
        vs_pulse();
        for (int i = 0; i < 50; i++) cyc(0, '0, 0, 1, 0, 0);
        chk("mid_lvl", 32'(level), 32'd300);
        do_reset();
        cyc(0, '0, 0, 0, 0, 0);
        chk("mid_idle_run", 32'(running), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 999) do_reset();
            cyc($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0, $urandom_range(0, 30) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
